// File: rtl/ejector_fifo_pkg.sv
// ejector_fifo_pkg: shared defaults and helpers for the local ejection path.
// The one-hot/popcount check is also used by the port allocator.
package ejector_fifo_pkg;

    localparam int WIDTH_PORT_DEF  = 64;
    localparam int NUM_CHANNEL_DEF = 5;
    localparam int MAX_VEC_W       = 32;

    // Result of classifying a request vector.
    typedef struct packed {
        logic multi;   // two or more bits set
        logic one;     // exactly one bit set
    } onehot_t;

    // Ceiling log2, usable in constant expressions (log2_ceil(1) = 0).
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Classify a (zero-extended) vector as empty, one-hot or multi-hot.
    // v & (v - 1) clears the lowest set bit; anything left means >= 2 bits.
    function automatic onehot_t onehot_check(input logic [MAX_VEC_W-1:0] vec);
        onehot_t res;
        res.multi = ((vec & (vec - 32'd1)) != 32'd0);
        res.one   = (vec != 32'd0) && !res.multi;
        return res;
    endfunction

endpackage

// File: rtl/ejector_fifo_onehot_mux.sv
// ejector_fifo_onehot_mux: combinational AND-OR select of one flit by a
// one-hot vector. The flit output is only meaningful when o_cand_valid is 1.
module ejector_fifo_onehot_mux
    import ejector_fifo_pkg::*;
#(
    parameter int WIDTH_PORT  = WIDTH_PORT_DEF,
    parameter int NUM_CHANNEL = NUM_CHANNEL_DEF
) (
    input  logic [NUM_CHANNEL*WIDTH_PORT-1:0] i_flit_in,
    input  logic [NUM_CHANNEL-1:0]            i_vector,
    output logic [WIDTH_PORT-1:0]             o_flit,
    output logic                              o_cand_valid,
    output logic                              o_multi_hot
);

    onehot_t w_class;

    // Classify the request vector.
    always_comb begin
        w_class      = onehot_check(MAX_VEC_W'(i_vector));
        o_cand_valid = w_class.one;
        o_multi_hot  = w_class.multi;
    end

    // AND-OR mux: each channel contributes only when its vector bit is set.
    always_comb begin
        o_flit = '0;
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            o_flit = o_flit | (i_flit_in[i*WIDTH_PORT +: WIDTH_PORT] & {WIDTH_PORT{i_vector[i]}});
        end
    end

endmodule

// File: rtl/ejector_fifo.sv
// ejector_fifo: selects the ejecting flit from NUM_CHANNEL inputs and queues
// it in a DEPTH-entry first-word-fall-through buffer towards the local PE.
// Optional macro EJECT_BYPASS_EN: an empty buffer with local_ready high hands
// a valid candidate straight to local_flit in the same cycle.
module ejector_fifo
    import ejector_fifo_pkg::*;
#(
    parameter int WIDTH_PORT  = WIDTH_PORT_DEF,
    parameter int NUM_CHANNEL = NUM_CHANNEL_DEF,
    parameter int DEPTH       = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNEL*WIDTH_PORT-1:0] flit_in,
    input  logic [NUM_CHANNEL-1:0]            local_vector,
    output logic                              eject_ready,
    output logic [WIDTH_PORT-1:0]             local_flit,
    output logic                              local_valid,
    input  logic                              local_ready,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy,
    output logic                              err_multi,
    output logic                              err_overflow
);

    localparam int PTR_W = log2_ceil(DEPTH);
    localparam int OCC_W = log2_ceil(DEPTH + 1);

    logic [WIDTH_PORT-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [OCC_W-1:0]      r_occ;
    logic                  r_err_multi;
    logic                  r_err_overflow;

    logic [WIDTH_PORT-1:0] w_cand_flit;
    logic                  w_cand_valid;
    logic                  w_multi_hot;
    logic                  w_buf_valid;
    logic                  w_ready;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_overflow_hit;

    ejector_fifo_onehot_mux #(
        .WIDTH_PORT  (WIDTH_PORT),
        .NUM_CHANNEL (NUM_CHANNEL)
    ) u_mux (
        .i_flit_in    (flit_in),
        .i_vector     (local_vector),
        .o_flit       (w_cand_flit),
        .o_cand_valid (w_cand_valid),
        .o_multi_hot  (w_multi_hot)
    );

    // Handshake decode; readiness comes only from registered occupancy, so a
    // same-cycle pop never rescues a push into a full buffer.
    always_comb begin
        w_buf_valid = (r_occ != OCC_W'(0));
        w_ready     = (r_occ != OCC_W'(DEPTH));
`ifdef EJECT_BYPASS_EN
        w_bypass    = !w_buf_valid && w_cand_valid && local_ready;
`else
        w_bypass    = 1'b0;
`endif
        w_push         = w_cand_valid && w_ready && !w_bypass;
        w_pop          = w_buf_valid && local_ready;
        w_overflow_hit = w_cand_valid && !w_ready;
    end

    // Output drive: bypassed candidate, else head of queue, else zero.
    always_comb begin
        eject_ready  = w_ready;
        occupancy    = r_occ;
        err_multi    = r_err_multi;
        err_overflow = r_err_overflow;
        if (w_bypass) begin
            local_valid = 1'b1;
            local_flit  = w_cand_flit;
        end else if (w_buf_valid) begin
            local_valid = 1'b1;
            local_flit  = r_mem[r_rd_ptr];
        end else begin
            local_valid = 1'b0;
            local_flit  = '0;
        end
    end

    // Buffer storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= w_cand_flit;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_occ          <= '0;
            r_err_multi    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_multi_hot) begin
                r_err_multi <= 1'b1;
            end
            if (w_overflow_hit) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ejector_fifo.sv
// tb_ejector_fifo: directed self-checking bench for ejector_fifo.
module tb_ejector_fifo;

    localparam int W  = 64;
    localparam int NC = 5;
    localparam int D  = 4;

    logic                clk;
    logic                reset;
    logic [NC*W-1:0]     flit_in;
    logic [NC-1:0]       local_vector;
    logic                eject_ready;
    logic [W-1:0]        local_flit;
    logic                local_valid;
    logic                local_ready;
    logic [2:0]          occupancy;
    logic                err_multi;
    logic                err_overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] q[$];
    logic [63:0] exp_v;

    ejector_fifo #(.WIDTH_PORT(W), .NUM_CHANNEL(NC), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .flit_in      (flit_in),
        .local_vector (local_vector),
        .eject_ready  (eject_ready),
        .local_flit   (local_flit),
        .local_valid  (local_valid),
        .local_ready  (local_ready),
        .occupancy    (occupancy),
        .err_multi    (err_multi),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a single-channel request (vec may differ from ch to test errors).
    task automatic drive(input logic [NC-1:0] vec, input int ch, input logic [63:0] val);
        flit_in = '0;
        flit_in[ch*W +: W] = val;
        local_vector = vec;
    endtask

    task automatic idle();
        flit_in = '0;
        local_vector = '0;
    endtask

    initial begin
        reset = 1'b1;
        local_ready = 1'b0;
        idle();
        step();
        step();
        reset = 1'b0;
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_valid", 64'(local_valid), 64'd0);
        check("rst_ready", 64'(eject_ready), 64'd1);
        check("rst_flit", local_flit, 64'd0);
        check("rst_errm", 64'(err_multi), 64'd0);
        check("rst_erro", 64'(err_overflow), 64'd0);

        // Test 1: fill on channels 0,1,2,4 then drain in order.
        drive(5'b00001, 0, 64'hA1); step();
        drive(5'b00010, 1, 64'hB2); step();
        drive(5'b00100, 2, 64'hC3); step();
        drive(5'b10000, 4, 64'hD4); step();
        idle();
        check("t1_occ", 64'(occupancy), 64'd4);
        check("t1_ready", 64'(eject_ready), 64'd0);
        check("t1_head", local_flit, 64'hA1);
        check("t1_erro", 64'(err_overflow), 64'd0);
        step();
        check("t1_hold", local_flit, 64'hA1);
        local_ready = 1'b1;
        q = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
        for (int k = 0; k < 4; k++) begin
            exp_v = q.pop_front();
            check("t1_valid", 64'(local_valid), 64'd1);
            check("t1_order", local_flit, exp_v);
            step();
        end
        check("t1_empty", 64'(local_valid), 64'd0);
        check("t1_occ0", 64'(occupancy), 64'd0);

        // Test 2: overflow on full buffer while popping.
        local_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(5'b00001, 0, 64'(k + 1));
            step();
        end
        drive(5'b01000, 3, 64'hEE);
        local_ready = 1'b1;
        step();
        idle();
        local_ready = 1'b0;
        check("t2_erro", 64'(err_overflow), 64'd1);
        check("t2_occ", 64'(occupancy), 64'd3);
        local_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            check("t2_order", local_flit, 64'(k));
            step();
        end
        check("t2_empty", 64'(local_valid), 64'd0);
        local_ready = 1'b0;

        // Test 3: multi-hot vector is rejected and flagged stickily.
        flit_in = '0;
        flit_in[1*W +: W] = 64'h11;
        flit_in[2*W +: W] = 64'h22;
        local_vector = 5'b00110;
        step();
        idle();
        check("t3_occ", 64'(occupancy), 64'd0);
        check("t3_errm", 64'(err_multi), 64'd1);
        step();
        step();
        check("t3_sticky", 64'(err_multi), 64'd1);
        check("t3_valid", 64'(local_valid), 64'd0);

        // Test 4: steady push+pop at occupancy 2 across pointer wrap.
        q = {};
        drive(5'b00001, 0, 64'h30); step(); q.push_back(64'h30);
        drive(5'b00001, 0, 64'h31); step(); q.push_back(64'h31);
        local_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(5'b00001, 0, 64'h40 + 64'(k));
            exp_v = q.pop_front();
            check("t4_order", local_flit, exp_v);
            q.push_back(64'h40 + 64'(k));
            step();
            check("t4_occ", 64'(occupancy), 64'd2);
        end
        idle();
        local_ready = 1'b0;

        // Test 5: reset together with a push at occupancy 3.
        drive(5'b00001, 0, 64'h60); step();
        check("t5_occ3", 64'(occupancy), 64'd3);
        drive(5'b00001, 0, 64'h77);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check("t5_occ", 64'(occupancy), 64'd0);
        check("t5_valid", 64'(local_valid), 64'd0);
        check("t5_errm", 64'(err_multi), 64'd0);
        check("t5_erro", 64'(err_overflow), 64'd0);
        check("t5_ready", 64'(eject_ready), 64'd1);
        check("t5_flit", local_flit, 64'd0);

        // Test 6: push into empty buffer with local_ready high.
        local_ready = 1'b1;
        drive(5'b00001, 0, 64'h99);
`ifdef EJECT_BYPASS_EN
        check("t6_byp_valid", 64'(local_valid), 64'd1);
        check("t6_byp_flit", local_flit, 64'h99);
        step();
        idle();
        check("t6_byp_occ", 64'(occupancy), 64'd0);
        check("t6_byp_after", 64'(local_valid), 64'd0);
`else
        check("t6_valid0", 64'(local_valid), 64'd0);
        step();
        idle();
        check("t6_occ", 64'(occupancy), 64'd1);
        check("t6_valid1", 64'(local_valid), 64'd1);
        check("t6_flit", local_flit, 64'h99);
        step();
        check("t6_occ0", 64'(occupancy), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
